mem_wb_skid_stage: RTL and testbench

//  Parametrised MEM/WB pipeline stage with load-data alignment, sign/zero extension and result selection at capture.

---
 rtl/mem_wb_skid_stage.sv | 134 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// rtl/mem_wb_skid_stage.sv - MEM/WB stage with load formatting and an in-order skid buffer toward writeback
module mem_wb_skid_stage #(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int SKID_DEPTH = 2,
    localparam int OFF_W     = $clog2(XLEN / 8),
    localparam int PTR_W     = $clog2(SKID_DEPTH),
    localparam int CNT_W     = $clog2(SKID_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [XLEN-1:0]    mem_alu_data,
    input  logic [XLEN-1:0]    mem_load_data,
    input  logic [OFF_W-1:0]   mem_byte_off,
    input  logic [2:0]         mem_funct3,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_regwrite,
    input  logic               mem_memtoreg,
    input  logic               stall,
    input  logic               flush,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [XLEN-1:0]    wb_data,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_regwrite,
    output logic               wb_misalign,
    output logic [CNT_W-1:0]   wb_count
);

    logic [XLEN-1:0]    data_q     [SKID_DEPTH];
    logic [RADDR_W-1:0] rd_q       [SKID_DEPTH];
    logic               regwrite_q [SKID_DEPTH];
    logic               misalign_q [SKID_DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic            full;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_fmt;
    logic            load_misal;
    logic [XLEN-1:0] cap_data;
    logic            cap_misal;
    logic            cap_regwrite;

    assign full      = (count_q == CNT_W'(SKID_DEPTH));
    assign mem_ready = !full;
    assign wb_valid  = (count_q != '0);
    assign push      = mem_valid && mem_ready && !stall && !flush;
    assign pop       = wb_valid && wb_ready && !stall && !flush;

    // Lane alignment: bring the addressed byte down to bit 0 before extension.
    assign shifted = mem_load_data >> {mem_byte_off, 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (mem_funct3)
            3'd0:    load_fmt = XLEN'($signed(shifted[7:0]));
            3'd1:    load_fmt = XLEN'($signed(shifted[15:0]));
            3'd2:    load_fmt = XLEN'($signed(shifted[31:0]));
            3'd4:    load_fmt = XLEN'(shifted[7:0]);
            3'd5:    load_fmt = XLEN'(shifted[15:0]);
            3'd6:    load_fmt = XLEN'(shifted[31:0]);
            default: load_fmt = shifted;
        endcase
    end

    always_comb begin
        load_misal = 1'b0;
        case (mem_funct3)
            3'd1, 3'd5: load_misal = mem_byte_off[0];
            3'd2, 3'd6: load_misal = |mem_byte_off[1:0];
            3'd3:       load_misal = (XLEN == 64) && (|mem_byte_off);
            default:    load_misal = 1'b0;
        endcase
    end

    // A misaligned load still takes a slot but must never reach the regfile.
    always_comb begin
        cap_misal    = mem_memtoreg && load_misal;
        cap_data     = mem_memtoreg ? load_fmt : mem_alu_data;
        cap_regwrite = mem_regwrite;
        if (cap_misal) begin
            cap_data     = '0;
            cap_regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                data_q[i]     <= '0;
                rd_q[i]       <= '0;
                regwrite_q[i] <= 1'b0;
                misalign_q[i] <= 1'b0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[tail_q]     <= cap_data;
                rd_q[tail_q]       <= mem_rd;
                regwrite_q[tail_q] <= cap_regwrite;
                misalign_q[tail_q] <= cap_misal;
                tail_q             <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign wb_count    = count_q;
    assign wb_data     = wb_valid ? data_q[head_q]     : '0;
    assign wb_rd       = wb_valid ? rd_q[head_q]       : '0;
    assign wb_regwrite = wb_valid ? regwrite_q[head_q] : 1'b0;
    assign wb_misalign = wb_valid ? misalign_q[head_q] : 1'b0;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb/tb_mem_wb_skid_stage.sv - directed self-checking bench for mem_wb_skid_stage
module tb_mem_wb_skid_stage;

    logic        clk;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_alu_data;
    logic [31:0] mem_load_data;
    logic [1:0]  mem_byte_off;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_misalign;
    logic [1:0]  wb_count;

    int checks;
    int errors;

    mem_wb_skid_stage #(.XLEN(32), .RADDR_W(5), .SKID_DEPTH(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_alu_data (mem_alu_data),
        .mem_load_data(mem_load_data),
        .mem_byte_off (mem_byte_off),
        .mem_funct3   (mem_funct3),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .stall        (stall),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_misalign  (wb_misalign),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [31:0] d, input logic [4:0] rd);
        mem_alu_data = d;
        mem_rd       = rd;
        mem_regwrite = 1'b1;
        mem_memtoreg = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] raw, input logic [1:0] off, input logic [2:0] f3, input logic [4:0] rd);
        mem_load_data = raw;
        mem_byte_off  = off;
        mem_funct3    = f3;
        mem_rd        = rd;
        mem_regwrite  = 1'b1;
        mem_memtoreg  = 1'b1;
    endtask

    task automatic push_tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic pop_tick();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, wb_valid, 1'b0);
        check({tag, "_count"}, wb_count, 2'd0);
        check({tag, "_data"}, wb_data, 32'h0);
        check({tag, "_rd"}, wb_rd, 5'd0);
        check({tag, "_rw"}, wb_regwrite, 1'b0);
        check({tag, "_mis"}, wb_misalign, 1'b0);
        check({tag, "_rdy"}, mem_ready, 1'b1);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
        set_load(32'h8001_80FF, off, f3, 5'd9);
        push_tick();
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_mis"}, wb_misalign, 1'b0);
        check({tag, "_rw"}, wb_regwrite, 1'b1);
        pop_tick();
        check({tag, "_cnt"}, wb_count, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        mem_valid     = 1'b0;
        mem_alu_data  = '0;
        mem_load_data = '0;
        mem_byte_off  = '0;
        mem_funct3    = '0;
        mem_rd        = '0;
        mem_regwrite  = 1'b0;
        mem_memtoreg  = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        wb_ready      = 1'b0;
        #12;
        check_empty("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // ALU result with 1-cycle latency, then drained
        wb_ready = 1'b1;
        set_alu(32'hDEADBEEF, 5'd5);
        push_tick();
        check("t1_valid", wb_valid, 1'b1);
        check("t1_data", wb_data, 32'hDEADBEEF);
        check("t1_rd", wb_rd, 5'd5);
        check("t1_rw", wb_regwrite, 1'b1);
        check("t1_cnt", wb_count, 2'd1);
        tick();
        check_empty("t1_drain");
        wb_ready = 1'b0;

        // Load formatting with raw word 0x800180FF
        load_case("lb0", 3'd0, 2'd0, 32'hFFFF_FFFF);
        load_case("lbu1", 3'd4, 2'd1, 32'h0000_0080);
        load_case("lh2", 3'd1, 2'd2, 32'hFFFF_8001);
        load_case("lhu2", 3'd5, 2'd2, 32'h0000_8001);
        load_case("lw0", 3'd2, 2'd0, 32'h8001_80FF);

        // Fill to full with writeback blocked
        set_alu(32'h11, 5'd1);
        push_tick();
        check("t3_cnt1", wb_count, 2'd1);
        check("t3_rdy1", mem_ready, 1'b1);
        set_alu(32'h22, 5'd2);
        push_tick();
        check("t3_cnt2", wb_count, 2'd2);
        check("t3_rdy2", mem_ready, 1'b0);
        set_alu(32'h33, 5'd3);
        push_tick();
        check("t3_cnt_full", wb_count, 2'd2);
        check("t3_head", wb_data, 32'h11);
        check("t3_head_rd", wb_rd, 5'd1);

        // Full with both sides active: only the pop happens
        mem_valid = 1'b1;
        wb_ready  = 1'b1;
        tick();
        check("t4_pop_only_cnt", wb_count, 2'd1);
        check("t4_head_b", wb_data, 32'h22);
        check("t4_rdy", mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        check("t4_pushpop_cnt", wb_count, 2'd1);
        check("t4_head_c", wb_data, 32'h33);
        check("t4_head_c_rd", wb_rd, 5'd3);
        tick();
        check("t4_drain_cnt", wb_count, 2'd0);
        check("t4_drain_valid", wb_valid, 1'b0);
        wb_ready = 1'b0;

        // Misaligned loads are buffered but disarmed
        set_load(32'h1234_5678, 2'd2, 3'd2, 5'd10);
        push_tick();
        set_load(32'h1234_5678, 2'd1, 3'd1, 5'd11);
        push_tick();
        check("t5_lw_mis", wb_misalign, 1'b1);
        check("t5_lw_rw", wb_regwrite, 1'b0);
        check("t5_lw_data", wb_data, 32'h0);
        check("t5_lw_rd", wb_rd, 5'd10);
        pop_tick();
        check("t5_lh_mis", wb_misalign, 1'b1);
        check("t5_lh_rw", wb_regwrite, 1'b0);
        check("t5_lh_data", wb_data, 32'h0);
        check("t5_lh_rd", wb_rd, 5'd11);
        pop_tick();
        check("t5_cnt", wb_count, 2'd0);

        // Stall freezes everything; flush overrides stall
        set_alu(32'hA1, 5'd7);
        push_tick();
        set_alu(32'hB2, 5'd8);
        push_tick();
        stall     = 1'b1;
        wb_ready  = 1'b1;
        mem_valid = 1'b1;
        set_alu(32'hC3, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_cnt", wb_count, 2'd2);
            check("t6_stall_data", wb_data, 32'hA1);
            check("t6_stall_rd", wb_rd, 5'd7);
        end
        flush = 1'b1;
        tick();
        check("t6_flush_cnt", wb_count, 2'd0);
        check("t6_flush_valid", wb_valid, 1'b0);
        flush     = 1'b0;
        stall     = 1'b0;
        mem_valid = 1'b0;
        wb_ready  = 1'b0;

        // Asynchronous reset between edges
        set_alu(32'hE5, 5'd12);
        push_tick();
        check("t6_prefill_cnt", wb_count, 2'd1);
        mem_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_empty("t6_areset");
        mem_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("t6_post_cnt", wb_count, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
